// File: rtl/mips_hazard_ctrl.sv
// Pipeline sequencing controller for the mips_16b 5-stage core: load-use stalls, MEM-resolved branches, HALT drain.
// Performance counters are built only when HAZARD_PERF_EN is defined; otherwise they read as zero.
module mips_hazard_ctrl #(
    parameter int CNT_W             = 32,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BR_PENALTY        = 3,
    parameter int DRAIN_CYCLES      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             mem_r_ex,
    input  logic [4:0]       dest_reg_ex,
    input  logic [4:0]       source1_id,
    input  logic [4:0]       source2_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic             halt_id,
    input  logic             branch_taken_mem,
    input  logic             retire_valid,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_src_branch,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] load_stall_count,
    output logic [CNT_W-1:0] branch_stall_count
);

    typedef enum logic [1:0] {RUN, LSTALL, DRAIN, HALTED} state_t;

    // The lu / halt cycle itself is the first stall / drain cycle, so the counter loads N-2.
    localparam logic [1:0] LSTALL_LOAD = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;
    localparam logic [1:0] DRAIN_LOAD  = (DRAIN_CYCLES > 1) ? 2'(DRAIN_CYCLES - 2) : 2'd0;

    state_t     state;
    state_t     state_nx;
    logic [1:0] cnt;
    logic [1:0] cnt_nx;
    logic       lu;
    logic       br;
    logic       stall;

    always_comb begin
        lu = mem_r_ex && (dest_reg_ex != 5'd0) &&
             ((uses_rs_id && (source1_id == dest_reg_ex)) ||
              (uses_rt_id && (source2_id == dest_reg_ex)));
        br    = branch_taken_mem && (state != HALTED);
        stall = !br && (((state == RUN) && lu) || (state == LSTALL));
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (br) begin
                    state_nx = RUN;
                    cnt_nx   = 2'd0;
                end else if (lu) begin
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nx = LSTALL;
                        cnt_nx   = LSTALL_LOAD;
                    end
                end else if (halt_id) begin
                    if (DRAIN_CYCLES == 1) begin
                        state_nx = HALTED;
                    end else begin
                        state_nx = DRAIN;
                        cnt_nx   = DRAIN_LOAD;
                    end
                end
            end
            LSTALL: begin
                if (br || (cnt == 2'd0)) begin
                    state_nx = RUN;
                    cnt_nx   = 2'd0;
                end else begin
                    cnt_nx = cnt - 2'd1;
                end
            end
            DRAIN: begin
                if (br) begin
                    state_nx = RUN;
                    cnt_nx   = 2'd0;
                end else if (cnt == 2'd0) begin
                    state_nx = HALTED;
                end else begin
                    cnt_nx = cnt - 2'd1;
                end
            end
            default: begin
                state_nx = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else if (clk_en) begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Control outputs act in the same cycle; reset dominates the freeze.
    always_comb begin
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        pc_src_branch = 1'b0;
        halted        = (state == HALTED);
        if (reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            halted      = 1'b0;
        end else if (!clk_en) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else if (state == HALTED) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (br) begin
            pc_src_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
        end else if (stall) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end else if ((state == DRAIN) || ((state == RUN) && halt_id)) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;
    logic [CNT_W-1:0] lstall_q;
    logic [CNT_W-1:0] bstall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q  <= '0;
            instr_q  <= '0;
            lstall_q <= '0;
            bstall_q <= '0;
        end else if (clk_en) begin
            if (state != HALTED) cycle_q <= cycle_q + CNT_W'(1);
            if (retire_valid) instr_q <= instr_q + CNT_W'(1);
            if (stall) lstall_q <= lstall_q + CNT_W'(1);
            if (br) bstall_q <= bstall_q + CNT_W'(BR_PENALTY);
        end
    end

    assign cycle_count        = cycle_q;
    assign instr_count        = instr_q;
    assign load_stall_count   = lstall_q;
    assign branch_stall_count = bstall_q;
`else
    logic perf_unused;
    assign perf_unused        = retire_valid;
    assign cycle_count        = '0;
    assign instr_count        = '0;
    assign load_stall_count   = '0;
    assign branch_stall_count = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Scoreboarded random bench for mips_hazard_ctrl: two instances with different parameters share stimulus.
// Counter expectations follow HAZARD_PERF_EN (zero when it is undefined).
module tb_mips_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]       ctl;  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pc_src_branch, halted}
        logic [3:0][31:0] cn;   // cycle, instr, load stall, branch stall
    } exp_t;

    logic clk = 1'b0;
    logic reset, clk_en, mem_r_ex, uses_rs_id, uses_rt_id, halt_id, branch_taken_mem, retire_valid;
    logic [4:0] dest_reg_ex, source1_id, source2_id;

    logic pc_we_a, ifid_we_a, ifid_flush_a, idex_flush_a, exmem_flush_a, pc_src_branch_a, halted_a;
    logic [31:0] cyc_a, ins_a, ls_a, bs_a;
    logic pc_we_b, ifid_we_b, ifid_flush_b, idex_flush_b, exmem_flush_b, pc_src_branch_b, halted_b;
    logic [3:0] cyc_b, ins_b, ls_b, bs_b;

    always #5 clk = ~clk;

    mips_hazard_ctrl u_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .mem_r_ex(mem_r_ex), .dest_reg_ex(dest_reg_ex),
        .source1_id(source1_id), .source2_id(source2_id), .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .halt_id(halt_id), .branch_taken_mem(branch_taken_mem), .retire_valid(retire_valid),
        .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a),
        .exmem_flush(exmem_flush_a), .pc_src_branch(pc_src_branch_a), .halted(halted_a),
        .cycle_count(cyc_a), .instr_count(ins_a), .load_stall_count(ls_a), .branch_stall_count(bs_a)
    );

    mips_hazard_ctrl #(.CNT_W(4), .LOAD_STALL_CYCLES(3), .BR_PENALTY(2), .DRAIN_CYCLES(1)) u_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .mem_r_ex(mem_r_ex), .dest_reg_ex(dest_reg_ex),
        .source1_id(source1_id), .source2_id(source2_id), .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .halt_id(halt_id), .branch_taken_mem(branch_taken_mem), .retire_valid(retire_valid),
        .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b),
        .exmem_flush(exmem_flush_b), .pc_src_branch(pc_src_branch_b), .halted(halted_b),
        .cycle_count(cyc_b), .instr_count(ins_b), .load_stall_count(ls_b), .branch_stall_count(bs_b)
    );

    // Reference model: remaining stall / drain cycles as plain integers.
    int     lsc[2] = '{1, 3};
    int     drn[2] = '{4, 1};
    int     brp[2] = '{3, 2};
    int     cw[2]  = '{32, 4};
    int     stall_left[2];
    int     drain_left[2];
    bit     draining[2];
    bit     hlt[2];
    longint cn[2][4];

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;

    task automatic model_step(input int k);
        exp_t   e;
        bit     lu;
        longint mask;
        mask = (longint'(1) << cw[k]) - 1;
        for (int i = 0; i < 4; i++) e.cn[i] = PERF ? 32'(cn[k][i] & mask) : 32'd0;
        lu = mem_r_ex && (dest_reg_ex != 0) &&
             ((uses_rs_id && source1_id == dest_reg_ex) || (uses_rt_id && source2_id == dest_reg_ex));
        e.ctl = 7'b1100000;
        if (reset) begin
            e.ctl = 7'b0011100;
            stall_left[k] = 0;
            drain_left[k] = 0;
            draining[k]   = 0;
            hlt[k]        = 0;
            for (int i = 0; i < 4; i++) cn[k][i] = 0;
        end else if (!clk_en) begin
            e.ctl = {6'b000000, hlt[k]};
        end else begin
            if (!hlt[k]) cn[k][0]++;
            if (retire_valid) cn[k][1]++;
            if (hlt[k]) begin
                e.ctl = 7'b0011101;
            end else if (branch_taken_mem) begin
                e.ctl = 7'b1111110;
                stall_left[k] = 0;
                draining[k]   = 0;
                cn[k][3] += brp[k];
            end else if (stall_left[k] > 0) begin
                e.ctl = 7'b0001000;
                stall_left[k]--;
                cn[k][2]++;
            end else if (draining[k]) begin
                e.ctl = 7'b0110000;
                drain_left[k]--;
                if (drain_left[k] == 0) begin
                    draining[k] = 0;
                    hlt[k]      = 1;
                end
            end else if (lu) begin
                e.ctl = 7'b0001000;
                stall_left[k] = lsc[k] - 1;
                cn[k][2]++;
            end else if (halt_id) begin
                e.ctl = 7'b0110000;
                if (drn[k] == 1) begin
                    hlt[k] = 1;
                end else begin
                    draining[k]   = 1;
                    drain_left[k] = drn[k] - 1;
                end
            end
        end
        if (k == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                chk("a_ctl", {25'd0, pc_we_a, ifid_we_a, ifid_flush_a, idex_flush_a, exmem_flush_a,
                              pc_src_branch_a, halted_a}, {25'd0, ea.ctl});
                chk("a_cycle_count", cyc_a, ea.cn[0]);
                chk("a_instr_count", ins_a, ea.cn[1]);
                chk("a_load_stall_count", ls_a, ea.cn[2]);
                chk("a_branch_stall_count", bs_a, ea.cn[3]);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                chk("b_ctl", {25'd0, pc_we_b, ifid_we_b, ifid_flush_b, idex_flush_b, exmem_flush_b,
                              pc_src_branch_b, halted_b}, {25'd0, eb.ctl});
                chk("b_cycle_count", {28'd0, cyc_b}, eb.cn[0]);
                chk("b_instr_count", {28'd0, ins_b}, eb.cn[1]);
                chk("b_load_stall_count", {28'd0, ls_b}, eb.cn[2]);
                chk("b_branch_stall_count", {28'd0, bs_b}, eb.cn[3]);
            end
        end
    end

    task automatic clr();
        reset = 0; clk_en = 1; mem_r_ex = 0; dest_reg_ex = 0; source1_id = 0; source2_id = 0;
        uses_rs_id = 0; uses_rt_id = 0; halt_id = 0; branch_taken_mem = 0; retire_valid = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic go();
        model_step(0);
        model_step(1);
    endtask

    task automatic lu_rs2();
        mem_r_ex = 1; dest_reg_ex = 5'd2; source1_id = 5'd2; uses_rs_id = 1;
    endtask

    initial begin
        clr();
        reset = 1;
        repeat (2) @(posedge clk);
        nxt(); reset = 1; go();
        nxt(); retire_valid = 1; go();
        // load-use on rs, then on rt, then dest r0 and unused rt
        nxt(); lu_rs2(); go();
        repeat (4) begin nxt(); go(); end
        nxt(); mem_r_ex = 1; dest_reg_ex = 5'd7; source2_id = 5'd7; uses_rt_id = 1; go();
        repeat (3) begin nxt(); go(); end
        nxt(); mem_r_ex = 1; dest_reg_ex = 5'd0; source1_id = 5'd0; uses_rs_id = 1; go();
        nxt(); mem_r_ex = 1; dest_reg_ex = 5'd7; source2_id = 5'd7; uses_rt_id = 0; go();
        // branch wins over lu and halt
        nxt(); lu_rs2(); halt_id = 1; branch_taken_mem = 1; go();
        nxt(); go();
        // halt drain, branch mid-drain cancels it
        nxt(); halt_id = 1; go();
        repeat (2) begin nxt(); go(); end
        nxt(); branch_taken_mem = 1; go();
        repeat (2) begin nxt(); go(); end
        // full drain into halted; halted ignores branch and freeze
        nxt(); halt_id = 1; go();
        repeat (6) begin nxt(); retire_valid = 1; go(); end
        nxt(); branch_taken_mem = 1; go();
        nxt(); clk_en = 0; go();
        nxt(); reset = 1; go();
        // freeze in the middle of a long load stall
        nxt(); lu_rs2(); go();
        repeat (5) begin nxt(); clk_en = 0; lu_rs2(); branch_taken_mem = 1; go(); end
        repeat (4) begin nxt(); go(); end
        // reset mid-stall, then 17 retires for the 4-bit wrap
        nxt(); lu_rs2(); go();
        nxt(); reset = 1; go();
        repeat (17) begin nxt(); retire_valid = 1; go(); end
        nxt(); go();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            nxt();
            reset            = ($urandom_range(0, 59) == 0);
            clk_en           = ($urandom_range(0, 5) != 0);
            mem_r_ex         = 1'($urandom_range(0, 1));
            dest_reg_ex      = 5'($urandom_range(0, 3));
            source1_id       = 5'($urandom_range(0, 3));
            source2_id       = 5'($urandom_range(0, 3));
            uses_rs_id       = 1'($urandom_range(0, 1));
            uses_rt_id       = 1'($urandom_range(0, 1));
            halt_id          = ($urandom_range(0, 19) == 0);
            branch_taken_mem = ($urandom_range(0, 7) == 0);
            retire_valid     = 1'($urandom_range(0, 1));
            go();
        end
        nxt();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
